// File: rtl/pcss_flit_pkg.sv
// Shared flit definitions for the node NoC interface: type codes, field positions,
// default widths and the spike-in receiver state encoding.
package pcss_flit_pkg;

   localparam int FW_DEF  = 59;
   localparam int FTW_DEF = 3;
   localparam int SW_DEF  = 24;
   localparam int R_FLG   = 36;

   localparam logic [FTW_DEF-1:0] FT_SPIKE    = 3'b000;
   localparam logic [FTW_DEF-1:0] FT_DATA     = 3'b001;
   localparam logic [FTW_DEF-1:0] FT_DATA_END = 3'b010;
   localparam logic [FTW_DEF-1:0] FT_WRITE    = 3'b110;
   localparam logic [FTW_DEF-1:0] FT_READ     = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SPIKE = 2'd2,
      S_CFG   = 2'd3
   } spk_in_state_t;

   typedef enum logic [1:0] {
      CLS_SPIKE   = 2'd0,
      CLS_CFG     = 2'd1,
      CLS_ILLEGAL = 2'd2
   } flit_class_t;

   function automatic flit_class_t classify(input logic [FTW_DEF-1:0] ftype);
      flit_class_t cls;
      case (ftype)
         FT_SPIKE:                              cls = CLS_SPIKE;
         FT_DATA, FT_DATA_END, FT_WRITE, FT_READ: cls = CLS_CFG;
         default:                               cls = CLS_ILLEGAL;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/data_fifo.sv
// Synchronous FIFO with registered read data: dout is valid the cycle after rd_en.
// Writes while full and reads while empty are ignored.
module data_fifo #(
   parameter int DATA_WIDTH = 59,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  full,
   output logic                  empty
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] r_wptr;
   logic [ADDR_WIDTH-1:0] r_rptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  w_wr;
   logic                  w_rd;

   assign w_wr  = wr_en & ~full;
   assign w_rd  = rd_en & ~empty;
   assign full  = (r_count == (ADDR_WIDTH+1)'(DEPTH));
   assign empty = (r_count == '0);

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         dout    <= '0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + ADDR_WIDTH'(1);
         if (w_rd) begin
            r_rptr <= r_rptr + ADDR_WIDTH'(1);
            dout   <= r_mem[r_rptr];
         end
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + (ADDR_WIDTH+1)'(1);
            2'b01:   r_count <= r_count - (ADDR_WIDTH+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/spk_in.sv
// Node-side NoC flit receiver: buffers flits, returns credits, and dispatches spikes and
// config flits over valid/ready. Define SPK_IN_ERR_EN to build the error flag/counter.
module spk_in
   import pcss_flit_pkg::*;
#(
   parameter int B   = 4,
   parameter int FW  = FW_DEF,
   parameter int FTW = FTW_DEF,
   parameter int SW  = SW_DEF,
   parameter int ECW = 8
) (
   input  logic           clk_spk_in,
   input  logic           rst_n,
   input  logic           flit_in_wr,
   input  logic [FW-1:0]  flit_in,
   output logic           credit_out,
   output logic           spk_in_valid,
   input  logic           spk_in_ready,
   output logic [SW-1:0]  spk_in_neuid,
   output logic           cfg_in_valid,
   input  logic           cfg_in_ready,
   output logic [FTW-1:0] cfg_in_type,
   output logic [FW-1:0]  cfg_in_data,
   output logic           spk_in_err,
   output logic [ECW-1:0] spk_in_err_cnt
);

   spk_in_state_t r_state;
   spk_in_state_t w_next;
   flit_class_t   w_class;
   logic [FW-1:0] r_out;
   logic [FW-1:0] w_dout;
   logic          r_credit;
   logic          w_push;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;

   // A push into a full FIFO is dropped here so it can never earn a credit.
   assign w_push  = flit_in_wr & ~w_full;
   assign w_class = classify(w_dout[FW-1 -: FTW]);

   data_fifo #(
      .DATA_WIDTH (FW),
      .ADDR_WIDTH (B)
   ) u_fifo (
      .clk   (clk_spk_in),
      .rst_n (rst_n),
      .wr_en (w_push),
      .din   (flit_in),
      .rd_en (w_pop),
      .dout  (w_dout),
      .full  (w_full),
      .empty (w_empty)
   );

   always_ff @(posedge clk_spk_in or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) w_next = S_LOAD;
         end
         S_LOAD: begin
            case (w_class)
               CLS_SPIKE: w_next = S_SPIKE;
               CLS_CFG:   w_next = S_CFG;
               default:   w_next = S_IDLE;
            endcase
         end
         S_SPIKE: begin
            if (spk_in_ready) w_next = w_empty ? S_IDLE : S_LOAD;
         end
         S_CFG: begin
            if (cfg_in_ready) w_next = w_empty ? S_IDLE : S_LOAD;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_pop        = 1'b0;
      spk_in_valid = 1'b0;
      cfg_in_valid = 1'b0;
      case (r_state)
         S_IDLE: w_pop = ~w_empty;
         S_SPIKE: begin
            spk_in_valid = 1'b1;
            w_pop        = spk_in_ready & ~w_empty;
         end
         S_CFG: begin
            cfg_in_valid = 1'b1;
            w_pop        = cfg_in_ready & ~w_empty;
         end
         default: w_pop = 1'b0;
      endcase
   end

   always_ff @(posedge clk_spk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_out    <= '0;
         r_credit <= 1'b0;
      end else begin
         r_credit <= w_pop;
         if (r_state == S_LOAD) r_out <= w_dout;
      end
   end

   assign credit_out   = r_credit;
   assign spk_in_neuid = r_out[SW-1:0];
   assign cfg_in_type  = r_out[FW-1 -: FTW];
   assign cfg_in_data  = r_out;

`ifdef SPK_IN_ERR_EN
   logic           w_err_ill;
   logic           w_err_ovf;
   logic [1:0]     w_err_inc;
   logic [ECW:0]   w_cnt_sum;
   logic           r_err;
   logic [ECW-1:0] r_err_cnt;

   assign w_err_ill = (r_state == S_LOAD) && (w_class == CLS_ILLEGAL);
   assign w_err_ovf = flit_in_wr & w_full;
   assign w_err_inc = {1'b0, w_err_ill} + {1'b0, w_err_ovf};
   // One extra bit so two simultaneous events near the top still saturate cleanly.
   assign w_cnt_sum = {1'b0, r_err_cnt} + {{(ECW-1){1'b0}}, w_err_inc};

   always_ff @(posedge clk_spk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_err     <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         if (w_err_ill | w_err_ovf) r_err <= 1'b1;
         if (w_cnt_sum[ECW]) r_err_cnt <= '1;
         else                r_err_cnt <= w_cnt_sum[ECW-1:0];
      end
   end

   assign spk_in_err     = r_err;
   assign spk_in_err_cnt = r_err_cnt;
`else
   assign spk_in_err     = 1'b0;
   assign spk_in_err_cnt = '0;
`endif

endmodule
